lfsr_gen: RTL
=============

Name: lfsr_gen

Overview:
Parametrised successor to the team's fixed 4-bit LED LFSR. Generates a Fibonacci LFSR sequence of configurable width and tap mask, in XOR or XNOR mode, and advances it on an internal prescaler tick. Adds enable, runtime seed load, a step-strobe output and lock-up detection. Sits between the board clock and LED/pattern consumers; one instance per pattern channel.

Parameters:
WIDTH, 4, LFSR state width in bits (2..32).
TAPS, 4'b1100, tap mask [WIDTH-1:0]; bit i=1 means state[i] feeds the parity.
XNOR_MODE, 1, 1 selects XNOR feedback (lock-up state is all-ones); 0 selects XOR (lock-up state is all-zeros).
SEED, 0, reset value of the state [WIDTH-1:0].
COUNT_WIDTH, 32, prescaler counter width.
MAX_COUNT, 25_000_000, terminal count; the step period is MAX_COUNT+1 clk cycles (250 ms at 100 MHz).

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  1 = prescaler runs and state may step; 0 = freeze both
load  in  1  1-cycle strobe: load seed_in into the state
seed_in  in  WIDTH  value loaded on load
out  out  WIDTH  current LFSR state (registered)
tick  out  1  1-cycle pulse, high in the cycle in which out shows a newly stepped value
lockup  out  1  registered; high while out equals the lock-up state

Behaviour:
- Reset (rst=1 at the edge): out=SEED, counter=0, tick=0, lockup = (SEED==lock-up state). rst overrides every other input.
- Feedback: fb = ^(out & TAPS), inverted when XNOR_MODE=1. Step: out <= {out[WIDTH-2:0], fb}.
- Prescaler: when enable=1 and counter<MAX_COUNT, counter increments. When enable=1 and counter==MAX_COUNT, counter <= 0 and the state steps. Counter wraps only through this path and never overflows COUNT_WIDTH.
- tick is registered: it is 1 in exactly the cycle after a step edge and 0 otherwise.
- enable=0: counter, out and lockup hold; tick=0.
- load=1 (and rst=0): out <= seed_in, counter <= 0, tick <= 0. This applies regardless of enable. load wins over a coincident step, and no step occurs in that cycle.
- Lock-up state: all-ones when XNOR_MODE=1, all-zeros when XNOR_MODE=0. lockup <= (next out == lock-up state), so it tracks out with no lag.
- Latency: with enable held high after reset or load, the first step edge is edge MAX_COUNT+1, and steps then repeat every MAX_COUNT+1 cycles.
- MAX_COUNT=0: the state steps every enabled cycle and tick stays high continuously.

Optional Feature:
LFSR_LOCKUP_RECOVER_EN.
- Defined: at a step edge where out equals the lock-up state, out <= SEED instead of fb-shifted; tick still pulses. If SEED itself equals the lock-up state, out <= SEED with bit 0 inverted.
- Undefined: no recovery; the LFSR stays in lock-up (a step maps it to itself) and lockup stays high until load or rst.

Decomposition:
- Package lfsr_pkg: typedef enum {FB_XOR, FB_XNOR} lfsr_fb_t; default tap-mask constants for widths 4/8/16/32 (maximal-length); function lfsr_lockup_val(width, mode).
- One sub-module is natural: tick_prescaler (clk, rst, enable, clear -> step). It owns the counter and MAX_COUNT compare, and is reused by other blinker blocks.

Test Plan:
- Defaults except MAX_COUNT=3, enable=1 after reset: out sequence 0000,0001,0011,0111,1110,1101 with one step every 4 cycles; tick high exactly once per step; period 15 before 0000 recurs.
- enable=0 for 10 cycles mid-count: out and counter frozen, tick=0. Re-enable: the step lands after the remaining count, not after a fresh one.
- load with seed_in=4'b1010 in the same cycle as a terminal count: out=1010 next cycle, no tick, next step 4 cycles later to 0100.
- load seed_in=4'b1111 (XNOR): lockup=1 next cycle. Macro undefined: out stays 1111 across steps. Macro defined: the next step gives out=0000 and lockup=0.
- rst asserted mid-period together with load: out=SEED, counter=0, tick=0; load ignored.
- WIDTH=8, TAPS=8'hB8, XNOR_MODE=0, SEED=8'h01, MAX_COUNT=0: 255 distinct states before repeat; lockup never asserted.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: feedback mode, maximal-length default tap masks
// and the lock-up value helper.
package lfsr_pkg;

  typedef enum logic {FB_XOR, FB_XNOR} lfsr_fb_t;

  localparam logic [3:0]  LFSR_TAPS_4  = 4'b1100;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // XOR feedback gets stuck at all-zeros, XNOR feedback at all-ones.
  function automatic logic [31:0] lfsr_lockup_val(input int width, input lfsr_fb_t mode);
    logic [31:0] v;
    v = '0;
    if (mode == FB_XNOR) begin
      for (int i = 0; i < 32; i++) begin
        if (i < width) v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/lfsr_gen_tick_prescaler.sv
// Free-running prescaler: raises step for one cycle each time the enabled
// counter reaches MAX_COUNT; clear restarts the count.
module tick_prescaler #(
  parameter int COUNT_WIDTH = 32,
  parameter int MAX_COUNT   = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam logic [COUNT_WIDTH-1:0] TERM = COUNT_WIDTH'(MAX_COUNT);

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == TERM) count <= '0;
      else               count <= count + COUNT_WIDTH'(1);
    end
  end

  assign step = enable && !clear && (count == TERM);

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR pattern generator stepped by a prescaler tick.
// Optional macro LFSR_LOCKUP_RECOVER_EN reseeds the state out of lock-up.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
  parameter int               XNOR_MODE   = 1,
  parameter logic [WIDTH-1:0] SEED        = '0,
  parameter int               COUNT_WIDTH = 32,
  parameter int               MAX_COUNT   = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             lockup
);

  localparam lfsr_fb_t         FB_MODE  = (XNOR_MODE != 0) ? FB_XNOR : FB_XOR;
  localparam logic [31:0]      LOCK_ALL = lfsr_lockup_val(WIDTH, FB_MODE);
  localparam logic [WIDTH-1:0] LOCK_VAL = LOCK_ALL[WIDTH-1:0];

  logic             step;
  logic             fb;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] nxt;

  tick_prescaler #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .MAX_COUNT   (MAX_COUNT)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (load),
    .step   (step)
  );

  assign fb      = (^(out & TAPS)) ^ (FB_MODE == FB_XNOR);
  assign shifted = {out[WIDTH-2:0], fb};

`ifdef LFSR_LOCKUP_RECOVER_EN
  // A lock-up seed would recover straight back into lock-up, so perturb bit 0.
  localparam logic [WIDTH-1:0] RECOVER_VAL =
    (SEED == LOCK_VAL) ? (SEED ^ WIDTH'(1)) : SEED;
  assign nxt = (out == LOCK_VAL) ? RECOVER_VAL : shifted;
`else
  assign nxt = shifted;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= SEED;
      tick   <= 1'b0;
      lockup <= (SEED == LOCK_VAL);
    end else if (load) begin
      out    <= seed_in;
      tick   <= 1'b0;
      lockup <= (seed_in == LOCK_VAL);
    end else if (step) begin
      out    <= nxt;
      tick   <= 1'b1;
      lockup <= (nxt == LOCK_VAL);
    end else begin
      tick   <= 1'b0;
    end
  end

endmodule
